alu_issue: RTL and testbench

Sequential execute-stage front end for the Eka core's combinational ALU. Accepts one decoded OP/OP-IMM instruction via a valid/ready handshake, translates opcode/funct3/funct7 into the 4-bit ALU control code, and drives the ALU operands. It captures the ALU result and returns it on an output handshake. Shifts, which the ALU does not implement, run in a one-bit-per-cycle serial shifter.

---
 rtl/eka_pkg.sv | 30 +++
 rtl/serial_shifter.sv | 50 +++++
 rtl/alu_issue.sv | 227 ++++++++++++++++++++++
 tb/tb_alu_issue.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/eka_pkg.sv
// Shared Eka execute-stage definitions: ALU control codes, opcodes and issue FSM states.
// The SHIFT state exists only when ALU_SHIFT_EN is defined.
package eka_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned CTRL_W  = 4;
    localparam int unsigned OPC_W   = 7;

    localparam logic [CTRL_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [CTRL_W-1:0] ALU_SUB  = 4'b1000;
    localparam logic [CTRL_W-1:0] ALU_SLT  = 4'b0010;
    localparam logic [CTRL_W-1:0] ALU_SLTU = 4'b0011;
    localparam logic [CTRL_W-1:0] ALU_XOR  = 4'b0100;
    localparam logic [CTRL_W-1:0] ALU_OR   = 4'b0110;
    localparam logic [CTRL_W-1:0] ALU_AND  = 4'b0111;

    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
`ifdef ALU_SHIFT_EN
        ST_SHIFT = 2'd3,
`endif
        ST_DONE  = 2'd2
    } issue_state_e;

endpackage

// File: rtl/serial_shifter.sv
// One-bit-per-cycle shifter for SLL/SRL/SRA; used by alu_issue only when ALU_SHIFT_EN is defined.
// shifted_c is the next step's value and done_c flags the final step, so the caller can finish on the same edge.
module serial_shifter
    import eka_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [XLEN-1:0]    value,
    input  logic [SHAMT_W-1:0] amount,
    input  logic               direction,
    input  logic               arithmetic,
    output logic [XLEN-1:0]    shifted_c,
    output logic               done_c
);

    logic [XLEN-1:0]    val_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic               right_q;
    logic               arith_q;

    // direction=1 shifts right; arithmetic replicates the sign bit
    always_comb begin
        if (right_q) begin
            shifted_c = {arith_q & val_q[XLEN-1], val_q[XLEN-1:1]};
        end else begin
            shifted_c = {val_q[XLEN-2:0], 1'b0};
        end
    end

    assign done_c = (cnt_q == SHAMT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q   <= '0;
            cnt_q   <= '0;
            right_q <= 1'b0;
            arith_q <= 1'b0;
        end else if (load) begin
            val_q   <= value;
            cnt_q   <= amount;
            right_q <= direction;
            arith_q <= arithmetic;
        end else if (cnt_q != '0) begin
            val_q <= shifted_c;
            cnt_q <= cnt_q - SHAMT_W'(1);
        end
    end

endmodule

// File: rtl/alu_issue.sv
// Execute-stage front end: decodes one OP/OP-IMM instruction, drives the external ALU, returns the result.
// ALU_SHIFT_EN adds the serial shifter for SLL/SRL/SRA; without it those encodings report illegal.
module alu_issue
    import eka_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPC_W-1:0]  opcode,
    input  logic [2:0]        funct3,
    input  logic              funct7b5,
    input  logic [XLEN-1:0]   rs1_val,
    input  logic [XLEN-1:0]   rs2_val,
    input  logic [XLEN-1:0]   imm,
    output logic [XLEN-1:0]   alu_src1,
    output logic [XLEN-1:0]   alu_src2,
    output logic [CTRL_W-1:0] ALU_Ctrl,
    input  logic [XLEN-1:0]   ALU_result,
    input  logic              zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   result,
    output logic              illegal
);

    issue_state_e      state_q, state_d;
    logic [XLEN-1:0]   src1_d, src2_d, result_d;
    logic [CTRL_W-1:0] ctrl_d;
    logic              illegal_d, out_valid_d;
    logic              op_illegal_q, op_illegal_d;

    logic              is_op, is_opimm, op_alt;
    logic [CTRL_W-1:0] dec_ctrl;
    logic [XLEN-1:0]   dec_op2;
    logic              dec_illegal, dec_shift, dec_right, dec_arith;

    // zero flag is reserved for future branch use
    logic              unused_zero;
    assign unused_zero = zero;

    assign is_op    = (opcode == OPC_OP);
    assign is_opimm = (opcode == OPC_OP_IMM);
    assign op_alt   = is_op & funct7b5;

    // instruction decode from the live input fields, latched on accept
    always_comb begin
        dec_ctrl    = ALU_ADD;
        dec_op2     = is_op ? rs2_val : imm;
        dec_illegal = 1'b0;
        dec_shift   = 1'b0;
        dec_right   = 1'b0;
        dec_arith   = 1'b0;
        if (!is_op && !is_opimm) begin
            dec_illegal = 1'b1;
        end else begin
            case (funct3)
                3'b000: dec_ctrl = op_alt ? ALU_SUB : ALU_ADD;
                3'b001: begin
                    dec_shift   = 1'b1;
                    dec_illegal = funct7b5;
                end
                3'b010: begin
                    dec_ctrl    = ALU_SLT;
                    dec_illegal = op_alt;
                end
                3'b011: begin
                    dec_ctrl    = ALU_SLTU;
                    dec_illegal = op_alt;
                end
                3'b100: begin
                    dec_ctrl    = ALU_XOR;
                    dec_illegal = op_alt;
                end
                3'b101: begin
                    dec_shift = 1'b1;
                    dec_right = 1'b1;
                    dec_arith = funct7b5;
                end
                3'b110: begin
                    dec_ctrl    = ALU_OR;
                    dec_illegal = op_alt;
                end
                default: begin
                    dec_ctrl    = ALU_AND;
                    dec_illegal = op_alt;
                end
            endcase
`ifndef ALU_SHIFT_EN
            if (dec_shift) begin
                dec_illegal = 1'b1;
            end
`endif
        end
    end

`ifdef ALU_SHIFT_EN
    logic            op_shift_q, op_shift_d;
    logic            shift_right_q, shift_right_d;
    logic            shift_arith_q, shift_arith_d;
    logic            sh_load, sh_done;
    logic [XLEN-1:0] sh_shifted;

    serial_shifter u_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (sh_load),
        .value      (alu_src1),
        .amount     (alu_src2[SHAMT_W-1:0]),
        .direction  (shift_right_q),
        .arithmetic (shift_arith_q),
        .shifted_c  (sh_shifted),
        .done_c     (sh_done)
    );
`else
    logic unused_dec;
    assign unused_dec = dec_right ^ dec_arith;
`endif

    // next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        src1_d       = '0;
        src2_d       = '0;
        ctrl_d       = ALU_ADD;
        result_d     = result;
        illegal_d    = illegal;
        out_valid_d  = 1'b0;
        op_illegal_d = op_illegal_q;
`ifdef ALU_SHIFT_EN
        op_shift_d    = op_shift_q;
        shift_right_d = shift_right_q;
        shift_arith_d = shift_arith_q;
        sh_load       = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d      = ST_EXEC;
                    src1_d       = rs1_val;
                    src2_d       = dec_op2;
                    ctrl_d       = dec_ctrl;
                    op_illegal_d = dec_illegal;
`ifdef ALU_SHIFT_EN
                    op_shift_d    = dec_shift & ~dec_illegal;
                    shift_right_d = dec_right;
                    shift_arith_d = dec_arith;
`endif
                end
            end
            ST_EXEC: begin
                state_d     = ST_DONE;
                out_valid_d = 1'b1;
                illegal_d   = op_illegal_q;
                if (op_illegal_q) begin
                    result_d = '0;
                end
`ifdef ALU_SHIFT_EN
                else if (op_shift_q) begin
                    sh_load  = 1'b1;
                    result_d = alu_src1;
                    if (alu_src2[SHAMT_W-1:0] != '0) begin
                        state_d     = ST_SHIFT;
                        out_valid_d = 1'b0;
                    end
                end
`endif
                else begin
                    result_d = ALU_result;
                end
            end
`ifdef ALU_SHIFT_EN
            ST_SHIFT: begin
                if (sh_done) begin
                    state_d     = ST_DONE;
                    result_d    = sh_shifted;
                    out_valid_d = 1'b1;
                end
            end
`endif
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            alu_src1     <= '0;
            alu_src2     <= '0;
            ALU_Ctrl     <= ALU_ADD;
            result       <= '0;
            illegal      <= 1'b0;
            out_valid    <= 1'b0;
            op_illegal_q <= 1'b0;
`ifdef ALU_SHIFT_EN
            op_shift_q    <= 1'b0;
            shift_right_q <= 1'b0;
            shift_arith_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            alu_src1     <= src1_d;
            alu_src2     <= src2_d;
            ALU_Ctrl     <= ctrl_d;
            result       <= result_d;
            illegal      <= illegal_d;
            out_valid    <= out_valid_d;
            op_illegal_q <= op_illegal_d;
`ifdef ALU_SHIFT_EN
            op_shift_q    <= op_shift_d;
            shift_right_q <= shift_right_d;
            shift_arith_q <= shift_arith_d;
`endif
        end
    end

    // ready only in IDLE and forced low while reset is held
    assign in_ready = rst_n & (state_q == ST_IDLE);

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural ALU and an expected-result queue.
// Shift expectations follow ALU_SHIFT_EN (serial shift when defined, illegal otherwise).
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic        funct7b5 = 1'b0;
    logic [31:0] rs1_val = '0;
    logic [31:0] rs2_val = '0;
    logic [31:0] imm = '0;
    logic [31:0] alu_src1, alu_src2;
    logic [3:0]  ALU_Ctrl;
    logic [31:0] ALU_result;
    logic        zero;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        illegal;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] res;
        logic        ill;
        int          lat;
    } exp_t;
    exp_t sb[$];

    localparam logic [6:0] OP  = 7'b0110011;
    localparam logic [6:0] OPI = 7'b0010011;

    alu_issue dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .rs1_val    (rs1_val),
        .rs2_val    (rs2_val),
        .imm        (imm),
        .alu_src1   (alu_src1),
        .alu_src2   (alu_src2),
        .ALU_Ctrl   (ALU_Ctrl),
        .ALU_result (ALU_result),
        .zero       (zero),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    // behavioural stand-in for the combinational ALU
    always_comb begin
        case (ALU_Ctrl)
            4'b0000: ALU_result = alu_src1 + alu_src2;
            4'b1000: ALU_result = alu_src1 - alu_src2;
            4'b0010: ALU_result = {31'd0, $signed(alu_src1) < $signed(alu_src2)};
            4'b0011: ALU_result = {31'd0, alu_src1 < alu_src2};
            4'b0100: ALU_result = alu_src1 ^ alu_src2;
            4'b0110: ALU_result = alu_src1 | alu_src2;
            4'b0111: ALU_result = alu_src1 & alu_src2;
            default: ALU_result = 32'd0;
        endcase
    end
    assign zero = (alu_src1 == alu_src2);

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ectrl of 4'hF skips the EXEC operand/control checks
    task automatic run_op(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                          input logic f7, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] im, input logic [3:0] ectrl,
                          input logic [31:0] eres, input logic eill, input int elat,
                          input int hold);
        exp_t e;
        int   cyc;
        @(negedge clk);
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        opcode   = opc;
        funct3   = f3;
        funct7b5 = f7;
        rs1_val  = a;
        rs2_val  = b;
        imm      = im;
        in_valid = 1'b1;
        e.res = eres;
        e.ill = eill;
        e.lat = elat;
        sb.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        if (ectrl != 4'hF) begin
            chk({tag, "_ctrl"}, 32'(ALU_Ctrl), 32'(ectrl));
            chk({tag, "_src1"}, alu_src1, a);
            chk({tag, "_src2"}, alu_src2, (opc == OP) ? b : im);
        end
        cyc = 1;
        while (!out_valid && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        e = sb.pop_front();
        chk({tag, "_latency"}, 32'(cyc), 32'(e.lat));
        chk({tag, "_result"}, result, e.res);
        chk({tag, "_illegal"}, 32'(illegal), 32'(e.ill));
        chk({tag, "_ctrl_idle"}, {28'd0, ALU_Ctrl} | alu_src1 | alu_src2, 32'd0);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_result"}, result, e.res);
            chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_back_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_ctrl", 32'(ALU_Ctrl), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        run_op("add",   OP,  3'b000, 1'b0, 32'd5, 32'd7, 32'd0, 4'b0000, 32'd12, 1'b0, 2, 0);
        run_op("sub",   OP,  3'b000, 1'b1, 32'd3, 32'd5, 32'd0, 4'b1000, 32'hFFFF_FFFE, 1'b0, 2, 0);
        run_op("addi7", OPI, 3'b000, 1'b1, 32'd10, 32'd99, 32'hFFFF_FFFF, 4'b0000, 32'd9, 1'b0, 2, 0);
        run_op("slt",   OP,  3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b0010, 32'd1, 1'b0, 2, 0);
        run_op("sltu",  OP,  3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b0011, 32'd0, 1'b0, 2, 0);
        run_op("xori",  OPI, 3'b100, 1'b0, 32'hF0F0_F0F0, 32'd0, 32'h0000_FFFF, 4'b0100, 32'hF0F0_0F0F, 1'b0, 2, 0);
        run_op("ori",   OPI, 3'b110, 1'b0, 32'h1234_0000, 32'd0, 32'h0000_005A, 4'b0110, 32'h1234_005A, 1'b0, 2, 0);
        run_op("andi",  OPI, 3'b111, 1'b0, 32'hDEAD_BEEF, 32'd0, 32'h0000_FF00, 4'b0111, 32'h0000_BE00, 1'b0, 2, 0);
        run_op("ill_opc", 7'b0000011, 3'b000, 1'b0, 32'd5, 32'd7, 32'd3, 4'hF, 32'd0, 1'b1, 2, 0);
        run_op("ill_slt7", OP, 3'b010, 1'b1, 32'd1, 32'd2, 32'd0, 4'hF, 32'd0, 1'b1, 2, 0);
        run_op("ill_xor7", OP, 3'b100, 1'b1, 32'd1, 32'd2, 32'd0, 4'hF, 32'd0, 1'b1, 2, 0);
        run_op("ill_slli7", OPI, 3'b001, 1'b1, 32'd1, 32'd0, 32'd3, 4'hF, 32'd0, 1'b1, 2, 0);
`ifdef ALU_SHIFT_EN
        run_op("sra",   OP,  3'b101, 1'b1, 32'h8000_0000, 32'd4, 32'd0, 4'hF, 32'hF800_0000, 1'b0, 6, 0);
        run_op("srl",   OP,  3'b101, 1'b0, 32'h8000_0000, 32'd4, 32'd0, 4'hF, 32'h0800_0000, 1'b0, 6, 0);
        run_op("sll",   OP,  3'b001, 1'b0, 32'd1, 32'd3, 32'd0, 4'hF, 32'd8, 1'b0, 5, 0);
        run_op("slli0", OPI, 3'b001, 1'b0, 32'hCAFE_F00D, 32'd9, 32'd0, 4'hF, 32'hCAFE_F00D, 1'b0, 2, 0);
        run_op("srai",  OPI, 3'b101, 1'b1, 32'h4000_0001, 32'd0, 32'd1, 4'hF, 32'h2000_0000, 1'b0, 3, 0);
`else
        run_op("sll_ill", OP, 3'b001, 1'b0, 32'd1, 32'd3, 32'd0, 4'hF, 32'd0, 1'b1, 2, 0);
        run_op("sra_ill", OP, 3'b101, 1'b1, 32'h8000_0000, 32'd4, 32'd0, 4'hF, 32'd0, 1'b1, 2, 0);
`endif
        run_op("hold",  OP,  3'b000, 1'b0, 32'd100, 32'd23, 32'd0, 4'b0000, 32'd123, 1'b0, 2, 5);

        // reset while busy: SHIFT when the shifter exists, DONE otherwise
        @(negedge clk);
        opcode   = OP;
        funct3   = 3'b101;
        funct7b5 = 1'b1;
        rs1_val  = 32'h8000_0000;
        rs2_val  = 32'd31;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_in_ready", 32'(in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_result", result, 32'd0);
        chk("arst_illegal", 32'(illegal), 32'd0);
        chk("arst_operands", alu_src1 | alu_src2 | {28'd0, ALU_Ctrl}, 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst_rel_in_ready", 32'(in_ready), 32'd1);
        run_op("add_after_rst", OP, 3'b000, 1'b0, 32'h0000_1000, 32'h0000_0234, 32'd0, 4'b0000, 32'h0000_1234, 1'b0, 2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
